// File: rtl/jtag_tap_ctrl_pkg.sv
// jtag_pkg: TAP state encoding, instruction opcodes and the IR capture
// pattern shared by the TAP controller and its FSM.
// Build option: JTAG_IDCODE_EN enables the IDCODE register and opcode.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PA_DR  = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PA_IR  = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_t;

    // Opcodes, zero-extended to the IR width by the user; BYPASS is all ones.
    localparam int unsigned OPC_EXTEST         = 0;
    localparam int unsigned OPC_IDCODE         = 1;
    localparam int unsigned OPC_SAMPLE_PRELOAD = 2;

    // Pattern loaded into the IR shift stage in Capture-IR ({0...0,01}).
    localparam int unsigned IR_CAPTURE = 1;

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if: connection between the TAP controller and the
// boundary-scan register chain. The TAP is the master; the BSR cells are
// the slave side.
// Build option: JTAG_IDCODE_EN (not used in this file).
interface jtag_tap_ctrl_if;
    logic bsr_tdi;
    logic bsr_tdo;
    logic shift_dr;
    logic capture_dr;
    logic update_dr;
    logic mode;

    modport master (
        output bsr_tdi, shift_dr, capture_dr, update_dr, mode,
        input  bsr_tdo
    );

    modport slave (
        input  bsr_tdi, shift_dr, capture_dr, update_dr, mode,
        output bsr_tdo
    );
endinterface

// File: rtl/jtag_tap_ctrl_fsm.sv
// jtag_tap_fsm: the 16-state TAP state machine. TMS is sampled on the rising
// edge of TCK; TRST (active low) forces Test-Logic-Reset asynchronously.
// next_state is exported so the controller can act on entry to TLR.
// Build option: JTAG_IDCODE_EN (not used in this file).
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_t state,
    output tap_state_t next_state
);

    // State register with asynchronous return to Test-Logic-Reset.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state <= TLR;
        end else begin
            state <= next_state;
        end
    end

    // Standard 1149.1 transition table; the IR branch mirrors the DR branch.
    always_comb begin
        next_state = TLR;
        case (state)
            TLR:     next_state = TMS ? TLR    : RTI;
            RTI:     next_state = TMS ? SEL_DR : RTI;
            SEL_DR:  next_state = TMS ? SEL_IR : CAP_DR;
            CAP_DR:  next_state = TMS ? EX1_DR : SH_DR;
            SH_DR:   next_state = TMS ? EX1_DR : SH_DR;
            EX1_DR:  next_state = TMS ? UPD_DR : PA_DR;
            PA_DR:   next_state = TMS ? EX2_DR : PA_DR;
            EX2_DR:  next_state = TMS ? UPD_DR : SH_DR;
            UPD_DR:  next_state = TMS ? SEL_DR : RTI;
            SEL_IR:  next_state = TMS ? TLR    : CAP_IR;
            CAP_IR:  next_state = TMS ? EX1_IR : SH_IR;
            SH_IR:   next_state = TMS ? EX1_IR : SH_IR;
            EX1_IR:  next_state = TMS ? UPD_IR : PA_IR;
            PA_IR:   next_state = TMS ? EX2_IR : PA_IR;
            EX2_IR:  next_state = TMS ? UPD_IR : SH_IR;
            UPD_IR:  next_state = TMS ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1-style TAP controller. Holds the instruction
// register, the BYPASS and (optionally) IDCODE data registers, drives the
// BSR strobes and muxes the selected register onto TDO on falling TCK.
// Build option: JTAG_IDCODE_EN adds the IDCODE register/opcode and makes
// IDCODE the reset instruction; without it the IR resets to BYPASS.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                tdo_en,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_value,
    jtag_tap_ctrl_if.master     bsr_bus
);

    localparam logic [IR_WIDTH-1:0] OP_EXTEST  = IR_WIDTH'(OPC_EXTEST);
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(OPC_SAMPLE_PRELOAD);
    localparam logic [IR_WIDTH-1:0] OP_BYPASS  = '1;
    localparam logic [IR_WIDTH-1:0] IR_CAP_VAL = IR_WIDTH'(IR_CAPTURE);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(OPC_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_RESET   = OP_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET   = OP_BYPASS;
`endif

    tap_state_t          state;
    tap_state_t          next_state;
    logic [IR_WIDTH-1:0] ir_shift;
    logic                bypass_reg;
    logic                sel_bsr;
    logic                dr_tdo;

    jtag_tap_fsm u_fsm (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .state      (state),
        .next_state (next_state)
    );

    // IR shift stage: capture the fixed pattern, then shift TDI in at the MSB.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_shift <= IR_CAP_VAL;
        end else if (state == CAP_IR) begin
            ir_shift <= IR_CAP_VAL;
        end else if (state == SH_IR) begin
            ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        end
    end

    // Active instruction: reverts on entry to TLR, loads when leaving Update-IR.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_value <= IR_RESET;
        end else if (next_state == TLR) begin
            ir_value <= IR_RESET;
        end else if (state == UPD_IR) begin
            ir_value <= ir_shift;
        end
    end

    // One-bit bypass register: cleared on capture so the first bit out is 0.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            bypass_reg <= 1'b0;
        end else if (state == CAP_DR) begin
            bypass_reg <= 1'b0;
        end else if (state == SH_DR) begin
            bypass_reg <= TDI;
        end
    end

    assign sel_bsr = (ir_value == OP_EXTEST) || (ir_value == OP_SAMPLE);

`ifdef JTAG_IDCODE_EN
    logic [31:0] id_reg;
    logic        sel_idcode;

    assign sel_idcode = (ir_value == OP_IDCODE);

    // Device ID register: load the ID on capture, shift out LSB first.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            id_reg <= IDCODE_VALUE;
        end else if (state == CAP_DR) begin
            id_reg <= IDCODE_VALUE;
        end else if (state == SH_DR) begin
            id_reg <= {TDI, id_reg[31:1]};
        end
    end

    // Serial output of whichever data register the instruction selects.
    always_comb begin
        dr_tdo = bypass_reg;
        if (sel_bsr) begin
            dr_tdo = bsr_bus.bsr_tdo;
        end else if (sel_idcode) begin
            dr_tdo = id_reg[0];
        end
    end
`else
    logic unused_idcode;
    assign unused_idcode = ^IDCODE_VALUE;

    // Serial output of whichever data register the instruction selects.
    always_comb begin
        dr_tdo = bypass_reg;
        if (sel_bsr) begin
            dr_tdo = bsr_bus.bsr_tdo;
        end
    end
`endif

    // TDO changes on falling TCK and holds outside the shift states.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            TDO <= 1'b0;
        end else if (state == SH_IR) begin
            TDO <= ir_shift[0];
        end else if (state == SH_DR) begin
            TDO <= dr_tdo;
        end
    end

    assign tdo_en             = (state == SH_DR) || (state == SH_IR);
    assign tap_state          = state;
    assign bsr_bus.bsr_tdi    = TDI;
    assign bsr_bus.mode       = (ir_value == OP_EXTEST);
    assign bsr_bus.shift_dr   = sel_bsr && (state == SH_DR);
    assign bsr_bus.capture_dr = sel_bsr && ((state == CAP_DR) || (state == SH_DR));
    assign bsr_bus.update_dr  = sel_bsr && (state == UPD_DR);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: scoreboard bench for jtag_tap_ctrl. Every TCK the stimulus
// side advances a behavioural TAP model and queues the expected outputs; a
// monitor pops and compares after each falling edge.
// Build option: JTAG_IDCODE_EN selects the IDCODE expectations.
module tb_jtag_tap_ctrl;

    localparam int          IR_W = 4;
    localparam logic [31:0] IDV  = 32'h1000_0001;
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] IR_RST = 4'h1;
`else
    localparam logic [IR_W-1:0] IR_RST = 4'hF;
`endif

    localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SEL_DR = 4'h7, S_CAP_DR = 4'h6,
                           S_SH_DR = 4'h2, S_EX1_DR = 4'h1, S_PA_DR = 4'h3, S_EX2_DR = 4'h0,
                           S_UPD_DR = 4'h5, S_SEL_IR = 4'h4, S_CAP_IR = 4'hE, S_SH_IR = 4'hA,
                           S_EX1_IR = 4'h9, S_PA_IR = 4'hB, S_EX2_IR = 4'h8, S_UPD_IR = 4'hD;

    typedef struct {
        logic [3:0]      st;
        logic            tdo;
        logic            tdo_en;
        logic            shift;
        logic            cap;
        logic            upd;
        logic            mode;
        logic            bsr_tdi;
        logic [IR_W-1:0] ir;
    } exp_t;

    logic            TCK = 1'b0;
    logic            TRST, TMS, TDI;
    logic            TDO, tdo_en;
    logic [3:0]      tap_state;
    logic [IR_W-1:0] ir_value;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state.
    logic [3:0]      m_state = S_TLR;
    logic [IR_W-1:0] m_ir    = IR_RST;
    logic [IR_W-1:0] m_irsh  = '0;
    logic            m_byp   = 1'b0;
    logic [31:0]     m_id    = '0;
    logic            m_tdo   = 1'b0;

    jtag_tap_ctrl_if bsr_bus ();

    jtag_tap_ctrl #(.IR_WIDTH(IR_W), .IDCODE_VALUE(IDV)) dut (
        .TCK       (TCK),
        .TRST      (TRST),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .tdo_en    (tdo_en),
        .tap_state (tap_state),
        .ir_value  (ir_value),
        .bsr_bus   (bsr_bus)
    );

    // Free-running test clock.
    always #5 TCK = ~TCK;

    function automatic logic [3:0] nextState(input logic [3:0] s, input logic tms);
        case (s)
            S_TLR:    return tms ? S_TLR    : S_RTI;
            S_RTI:    return tms ? S_SEL_DR : S_RTI;
            S_SEL_DR: return tms ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: return tms ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  return tms ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: return tms ? S_UPD_DR : S_PA_DR;
            S_PA_DR:  return tms ? S_EX2_DR : S_PA_DR;
            S_EX2_DR: return tms ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: return tms ? S_SEL_DR : S_RTI;
            S_SEL_IR: return tms ? S_TLR    : S_CAP_IR;
            S_CAP_IR: return tms ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  return tms ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: return tms ? S_UPD_IR : S_PA_IR;
            S_PA_IR:  return tms ? S_EX2_IR : S_PA_IR;
            S_EX2_IR: return tms ? S_UPD_IR : S_SH_IR;
            default:  return tms ? S_SEL_DR : S_RTI;
        endcase
    endfunction

    function automatic logic selBsr(input logic [IR_W-1:0] ir);
        return (ir == 4'h0) || (ir == 4'h2);
    endfunction

    function automatic logic selId(input logic [IR_W-1:0] ir);
`ifdef JTAG_IDCODE_EN
        return ir == 4'h1;
`else
        return (ir == 4'h1) && 1'b0;
`endif
    endfunction

    // One rising edge of the model, then the falling-edge TDO update.
    function automatic void modelStep(input logic tms, input logic tdi, input logic bdo);
        logic [3:0] ns;
        if (m_state == S_CAP_IR) m_irsh = 4'b0001;
        if (m_state == S_SH_IR)  m_irsh = {tdi, m_irsh[IR_W-1:1]};
        if (m_state == S_CAP_DR) begin m_byp = 1'b0; m_id = IDV; end
        if (m_state == S_SH_DR)  begin m_byp = tdi;  m_id = {tdi, m_id[31:1]}; end
        if (m_state == S_UPD_IR) m_ir = m_irsh;
        ns = nextState(m_state, tms);
        if (ns == S_TLR) m_ir = IR_RST;
        m_state = ns;
        if (m_state == S_SH_IR) m_tdo = m_irsh[0];
        else if (m_state == S_SH_DR)
            m_tdo = selBsr(m_ir) ? bdo : (selId(m_ir) ? m_id[0] : m_byp);
    endfunction

    function automatic void modelReset();
        m_state = S_TLR;
        m_ir    = IR_RST;
        m_tdo   = 1'b0;
    endfunction

    function automatic void pushExpected(input logic tdi);
        exp_t e;
        logic b;
        b         = selBsr(m_ir);
        e.st      = m_state;
        e.tdo     = m_tdo;
        e.tdo_en  = (m_state == S_SH_DR) || (m_state == S_SH_IR);
        e.shift   = b && (m_state == S_SH_DR);
        e.cap     = b && ((m_state == S_CAP_DR) || (m_state == S_SH_DR));
        e.upd     = b && (m_state == S_UPD_DR);
        e.mode    = (m_ir == 4'h0);
        e.bsr_tdi = tdi;
        e.ir      = m_ir;
        exp_q.push_back(e);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    endtask

    // Drive one TCK worth of pins; inputs change just after the falling edge.
    task automatic applyStimulus(input logic tms, input logic tdi, input logic bdo);
        TMS = tms;
        TDI = tdi;
        bsr_bus.bsr_tdo = bdo;
        @(posedge TCK);
        if (TRST == 1'b0) modelReset();
        else modelStep(tms, tdi, bdo);
        pushExpected(tdi);
        @(negedge TCK);
        #3;
    endtask

    // Monitor: compare every queued expectation after the falling edge.
    always @(negedge TCK) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("tap_state",  32'(tap_state),          32'(e.st));
            checkOutput("TDO",        32'(TDO),                32'(e.tdo));
            checkOutput("tdo_en",     32'(tdo_en),             32'(e.tdo_en));
            checkOutput("shift_dr",   32'(bsr_bus.shift_dr),   32'(e.shift));
            checkOutput("capture_dr", 32'(bsr_bus.capture_dr), 32'(e.cap));
            checkOutput("update_dr",  32'(bsr_bus.update_dr),  32'(e.upd));
            checkOutput("mode",       32'(bsr_bus.mode),       32'(e.mode));
            checkOutput("bsr_tdi",    32'(bsr_bus.bsr_tdi),    32'(e.bsr_tdi));
            checkOutput("ir_value",   32'(ir_value),           32'(e.ir));
        end
    end

    // From RTI: load an opcode, return the captured bits seen on TDO, end in RTI.
    task automatic shiftIr(input logic [IR_W-1:0] op, output logic [IR_W-1:0] captured);
        captured = '0;
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        captured[0] = TDO;
        for (int i = 0; i < IR_W; i++) begin
            applyStimulus(i == IR_W - 1, op[i], 0);
            if (i < IR_W - 1) captured[i+1] = TDO;
        end
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
    endtask

    // From RTI: n-bit DR scan; collects TDO and counts strobe/enable cycles.
    task automatic shiftDr(input int n, input logic [31:0] din, input logic [31:0] bdo,
                           output logic [31:0] dout, output int upd, output int cap, output int en);
        dout = '0; upd = 0; cap = 0; en = 0;
        for (int k = 0; k < n + 5; k++) begin
            if (k == 0)          applyStimulus(1, 0, 0);
            else if (k == 1)     applyStimulus(0, 0, 0);
            else if (k == 2)     applyStimulus(0, 0, bdo[0]);
            else if (k < n + 3)  applyStimulus(k == n + 2, din[k-3], (k - 3 < n - 1) ? bdo[k-2] : 1'b0);
            else if (k == n + 3) applyStimulus(1, 0, 0);
            else                 applyStimulus(0, 0, 0);
            if (k >= 2 && k < n + 2) dout[k-2] = TDO;
            upd += int'(bsr_bus.update_dr);
            cap += int'(bsr_bus.capture_dr);
            en  += int'(tdo_en);
        end
    endtask

    initial begin
        logic [31:0]     din, bdo, dout, mask;
        logic [IR_W-1:0] capd, op;
        int              upd, cap, en, n;

        TRST = 1'b0; TMS = 1'b1; TDI = 1'b0; bsr_bus.bsr_tdo = 1'b0;
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        checkOutput("reset_state", 32'(tap_state), 32'(S_TLR));
        checkOutput("reset_ir",    32'(ir_value),  32'(IR_RST));
        TRST = 1'b1;
        applyStimulus(0, 0, 0);

        // Default instruction: 32-bit DR scan.
        din = $urandom;
        shiftDr(32, din, 32'h0, dout, upd, cap, en);
`ifdef JTAG_IDCODE_EN
        checkOutput("default_dr_stream", dout, IDV);
`else
        checkOutput("default_dr_stream", dout, {din[30:0], 1'b0});
`endif
        checkOutput("default_dr_tdo_en_cycles", 32'(en), 32);
        checkOutput("default_dr_update_cycles", 32'(upd), 0);

        // BYPASS with 8'hA5.
        shiftIr(4'hF, capd);
        checkOutput("bypass_ir_capture", 32'(capd), 32'h1);
        shiftDr(8, 32'hA5, 32'h0, dout, upd, cap, en);
        checkOutput("bypass_stream", dout, 32'h4A);

        // EXTEST scan through the BSR.
        shiftIr(4'h0, capd);
        checkOutput("extest_mode", 32'(bsr_bus.mode), 32'h1);
        bdo = $urandom;
        shiftDr(12, $urandom, bdo, dout, upd, cap, en);
        checkOutput("extest_stream", dout, bdo & 32'hFFF);
        checkOutput("extest_update_cycles", 32'(upd), 1);
        checkOutput("extest_capture_cycles", 32'(cap), 13);

        // Unassigned opcode behaves as BYPASS.
        shiftIr(4'h6, capd);
        checkOutput("op0110_ir_capture", 32'(capd), 32'h1);
        din = $urandom;
        shiftDr(8, din, 32'hFF, dout, upd, cap, en);
        checkOutput("op0110_stream", dout, {24'h0, din[6:0], 1'b0});
        checkOutput("op0110_update_cycles", 32'(upd), 0);

        // TRST asserted in the middle of an EXTEST Shift-DR.
        shiftIr(4'h0, capd);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'($urandom), 1);
        TRST = 1'b0;
        #1;
        checkOutput("trst_state",     32'(tap_state),         32'(S_TLR));
        checkOutput("trst_tdo",       32'(TDO),               32'h0);
        checkOutput("trst_update_dr", 32'(bsr_bus.update_dr), 32'h0);
        checkOutput("trst_ir",        32'(ir_value),          32'(IR_RST));
        applyStimulus(0, 0, 0);
        TRST = 1'b1;
        applyStimulus(0, 0, 0);

        // Random opcode loads followed by random-length DR scans.
        for (int r = 0; r < 8; r++) begin
            case (r % 6)
                0: op = 4'h0;
                1: op = 4'h1;
                2: op = 4'h2;
                3: op = 4'hF;
                4: op = 4'h6;
                default: op = 4'($urandom);
            endcase
            shiftIr(op, capd);
            n    = $urandom_range(1, 20);
            mask = (32'd1 << n) - 32'd1;
            bdo  = $urandom;
            shiftDr(n, $urandom, bdo, dout, upd, cap, en);
            checkOutput("rand_update_cycles", 32'(upd), selBsr(op) ? 32'd1 : 32'd0);
            checkOutput("rand_tdo_en_cycles", 32'(en), 32'(n));
            if (selBsr(op)) checkOutput("rand_bsr_stream", dout, bdo & mask);
        end

        // Random TMS walks, each followed by five TMS=1 clocks.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 150; k++)
                applyStimulus(1'($urandom), 1'($urandom), 1'($urandom));
            for (int k = 0; k < 5; k++) applyStimulus(1, 1'($urandom), 1'($urandom));
            checkOutput("tms5_state",   32'(tap_state), 32'(S_TLR));
            checkOutput("tms5_ir",      32'(ir_value),  32'(IR_RST));
            checkOutput("tms5_strobes", {29'h0, bsr_bus.shift_dr, bsr_bus.capture_dr, bsr_bus.update_dr}, 32'h0);
        end

        repeat (2) @(negedge TCK);
        #3;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

IEEE 1149.1-style TAP controller that drives the boundary-scan chain. It decodes TMS into the 16-state TAP FSM and holds the instruction register. It generates shift_dr, capture_dr, update_dr and mode for every BSR cell, and muxes the selected data register (BSR, BYPASS, IDCODE) or the IR onto TDO. It sits between the chip-level JTAG pins and the first/last boundary-scan cells.

## Interface
- IR_WIDTH, 4, instruction register width; opcodes zero-extended, BYPASS is all ones.
- IDCODE_VALUE, 32'h1000_0001, device ID; bit 0 must be 1.
- TCK  in  1  test clock.
- TRST  in  1  reset TRST, asynchronous, active-low.
- TMS  in  1  mode select, sampled on posedge TCK.
- TDI  in  1  serial data in.
- TDO  out  1  serial data out, updated on negedge TCK.
- tdo_en  out  1  TDO output enable, 1 only in Shift-DR/Shift-IR.
- bsr_tdi  out  1  to scan_in of first BSR cell; equals TDI.
- bsr_tdo  in  1  from scan_out of last BSR cell.
- shift_dr  out  1  to all BSR cells.
- capture_dr  out  1  capture-stage clock enable to all BSR cells.
- update_dr  out  1  update-stage clock enable to all BSR cells.
- mode  out  1  BSR mode; 1 = control (pins driven from update stage).
- tap_state  out  4  current FSM state (debug).
- ir_value  out  IR_WIDTH  active instruction.

## Operation
- FSM, 16 states. Next state for TMS=0 / TMS=1:
  - TLR: RTI / TLR.
  - RTI: RTI / SEL_DR.
  - SEL_DR: CAP_DR / SEL_IR.
  - CAP_DR: SH_DR / EX1_DR.
  - SH_DR: SH_DR / EX1_DR.
  - EX1_DR: PA_DR / UPD_DR.
  - PA_DR: PA_DR / EX2_DR.
  - EX2_DR: SH_DR / UPD_DR.
  - UPD_DR: RTI / SEL_DR.
  - The IR branch (SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR) mirrors the DR branch; SEL_IR with TMS=1 goes to TLR.
- Five TCKs with TMS=1 reach TLR from any state.
- Instructions:
  - EXTEST 0000: selects BSR, mode=1.
  - IDCODE 0001: selects the 32-bit ID register.
  - SAMPLE_PRELOAD 0010: selects BSR, mode=0.
  - BYPASS 1111: selects the 1-bit bypass register.
  - Any other opcode decodes as BYPASS.
- IR shift stage:
  - CAP_IR loads {0…0,01}.
  - SH_IR shifts right, TDI into MSB, LSB to TDO.
  - UPD_IR copies the shift stage to ir_value.
- IR reset value (TRST low or state TLR): IDCODE with the macro defined, else BYPASS.
- Bypass register: loads 0 in CAP_DR, loads TDI in SH_DR.
- IDCODE register: loads IDCODE_VALUE in CAP_DR, shifts right with TDI into bit 31 in SH_DR.
- BSR strobes are asserted only when the BSR is selected:
  - shift_dr = SH_DR.
  - capture_dr = CAP_DR or SH_DR, because the cell's capture flop loads only while capture_dr=1.
  - update_dr = UPD_DR.
- mode depends on ir_value only, not on state; it is held through DR scans.
- TDO source: IR LSB in SH_IR; otherwise the selected DR's serial output.

## Timing
- State register on posedge TCK.
- shift_dr, capture_dr, update_dr, mode, tdo_en are Moore decodes of the registered state and ir_value, so BSR cells act on the posedge that leaves the state.
- UPD_DR lasts one TCK, giving exactly one update_dr pulse per DR scan.
- TDO is registered on negedge TCK. Path length TDI→TDO is 1 bit for BYPASS and 32 bits for IDCODE.
- Reset values: state TLR, TDO 0, tdo_en 0, all strobes 0, mode 0, ir_value per the macro.
- Reset mid-scan: TRST low aborts immediately; no update strobe is issued.
- Pause states: shift registers hold, TDO holds its last value, tdo_en=0.

## Configuration
- JTAG_IDCODE_EN defined: IDCODE register and opcode present; IR resets to IDCODE.
- JTAG_IDCODE_EN undefined: register removed, opcode 0001 decodes as BYPASS, IR resets to BYPASS.

## Structure
- Package jtag_pkg holds:
  - the tap_state_t enum, encoded TLR=4'hF, RTI=4'hC, SEL_DR=4'h7, CAP_DR=4'h6, SH_DR=4'h2, EX1_DR=4'h1, PA_DR=4'h3, EX2_DR=4'h0, UPD_DR=4'h5, SEL_IR=4'h4, CAP_IR=4'hE, SH_IR=4'hA, EX1_IR=4'h9, PA_IR=4'hB, EX2_IR=4'h8, UPD_IR=4'hD;
  - opcode localparams;
  - the IR capture constant.
- One sub-module, jtag_tap_fsm: TMS→state, pure next-state logic plus the state register.

## Test plan
- Random state, then TMS=1 for 5 TCKs → tap_state=TLR, ir_value=0001, all strobes 0.
- From reset, DR scan of 32 bits → TDO stream LSB first equals 32'h1000_0001; tdo_en=1 only during the shift.
- Load BYPASS, shift 8'hA5 on TDI → same pattern on TDO delayed by 1 TCK, first bit 0.
- Load EXTEST, DR scan with bsr_tdo looped → mode=1; capture_dr high in CAP_DR and SH_DR; exactly one update_dr cycle in UPD_DR.
- Load opcode 0110 → behaves as BYPASS; IR capture shifts out 0001 on TDO.
- TRST pulse low during SH_DR → immediate TLR, TDO=0, no update_dr; IR reverts to IDCODE, or to BYPASS without JTAG_IDCODE_EN.
